samm_feeder: RTL and testbench

Upstream stage of the systolic matrix multiplier `samm`. Accepts two full M×M signed matrices in one handshake and registers them. It then streams them as 2M−1 skewed wavefronts on `samm`'s packed 2·M·N-bit `A` bus, with `In_Dv` held high for the whole stream. It blocks further loads until `samm` reports completion.

---
 rtl/samm_pkg.sv | 34 +++
 rtl/samm_lane_sel.sv | 31 +++
 rtl/samm_feeder.sv | 114 +++++++++++
 tb/tb_samm_feeder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/samm_pkg.sv
// Shared definitions for the systolic matrix multiplier: states, step count,
// counter sizing and the element-slice helper.
package samm_pkg;

  localparam int unsigned SAMM_N = 8;
  localparam int unsigned SAMM_M = 8;
  localparam int unsigned STEPS  = 2 * SAMM_M - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2
  } state_e;

  function automatic int unsigned steps_for(input int unsigned m);
    return 2 * m - 1;
  endfunction

  // Step counter width; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned m);
    int unsigned s;
    s = 2 * m - 1;
    return (s > 1) ? $clog2(s) : 1;
  endfunction

  function automatic logic [SAMM_N-1:0] elem(
    input logic [SAMM_M*SAMM_M*SAMM_N-1:0] mat,
    input int unsigned                     r,
    input int unsigned                     c
  );
    return mat[(r*SAMM_M+c)*SAMM_N +: SAMM_N];
  endfunction

endpackage

// File: rtl/samm_lane_sel.sv
// Picks element (step - lane) of one matrix row/column for a skewed lane,
// or zero when that lane is outside the current wavefront.
module samm_lane_sel
  import samm_pkg::*;
#(
  parameter int unsigned N  = SAMM_N,
  parameter int unsigned M  = SAMM_M,
  parameter int unsigned TW = cnt_w(M)
) (
  input  logic [TW-1:0]  lane_i,
  input  logic [TW-1:0]  step_i,
  input  logic [M*N-1:0] vec_i,
  output logic [N-1:0]   elem_c_o
);

  localparam int unsigned DW = TW + 1;

  logic [DW-1:0] diff;

  // A negative difference sets the top bit, so it never matches an index.
  always_comb begin
    elem_c_o = '0;
    diff     = {1'b0, step_i} - {1'b0, lane_i};
    for (int unsigned c = 0; c < M; c++) begin
      if (diff == DW'(c)) begin
        elem_c_o = vec_i[c*N +: N];
      end
    end
  end

endmodule

// File: rtl/samm_feeder.sv
// Captures two MxM matrices and streams them to samm as 2M-1 skewed
// wavefronts, then holds off new loads until samm signals completion.
module samm_feeder
  import samm_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned M = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               In_Dv,
  input  logic [M*M*N-1:0]   Mat_A,
  input  logic [M*M*N-1:0]   Mat_B,
  input  logic               Mul_Done,
  output logic               In_Rdy,
  output logic               Out_Dv,
  output logic [2*M*N-1:0]   Out_A
);

  localparam int unsigned MW      = M * M * N;
  localparam int unsigned LW      = M * N;
  localparam int unsigned STEPS_L = steps_for(M);
  localparam int unsigned TW      = cnt_w(M);
  localparam logic [TW-1:0] T_LAST = TW'(STEPS_L - 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  logic [MW-1:0]   mat_a_q, mat_a_d;
  logic [MW-1:0]   mat_b_q, mat_b_d;
  logic            out_dv_q, out_dv_d;
  logic [2*LW-1:0] out_a_q, out_a_d;
  logic [2*LW-1:0] lanes_c;

  // Lane j of A takes row j; lane j of B takes column j.
  for (genvar j = 0; j < M; j++) begin : g_lane
    logic [LW-1:0] col_b;

    for (genvar r = 0; r < M; r++) begin : g_col
      assign col_b[r*N +: N] = mat_b_q[(r*M+j)*N +: N];
    end

    samm_lane_sel #(.N(N), .M(M), .TW(TW)) u_hor (
      .lane_i   (TW'(j)),
      .step_i   (t_q),
      .vec_i    (mat_a_q[j*LW +: LW]),
      .elem_c_o (lanes_c[j*N +: N])
    );

    samm_lane_sel #(.N(N), .M(M), .TW(TW)) u_ver (
      .lane_i   (TW'(j)),
      .step_i   (t_q),
      .vec_i    (col_b),
      .elem_c_o (lanes_c[LW + j*N +: N])
    );
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      t_q      <= '0;
      mat_a_q  <= '0;
      mat_b_q  <= '0;
      out_dv_q <= 1'b0;
      out_a_q  <= '0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      mat_a_q  <= mat_a_d;
      mat_b_q  <= mat_b_d;
      out_dv_q <= out_dv_d;
      out_a_q  <= out_a_d;
    end
  end

  // Next-state and next-output decode; outputs are zero outside STREAM.
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    mat_a_d  = mat_a_q;
    mat_b_d  = mat_b_q;
    out_dv_d = 1'b0;
    out_a_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (In_Dv) begin
          mat_a_d = Mat_A;
          mat_b_d = Mat_B;
          t_d     = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        out_dv_d = 1'b1;
        out_a_d  = lanes_c;
        if (t_q == T_LAST) begin
          state_d = WAIT;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      WAIT: begin
        if (Mul_Done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign In_Rdy = (state_q == IDLE);
  assign Out_Dv = out_dv_q;
  assign Out_A  = out_a_q;

endmodule

// File: tb/tb_samm_feeder.sv
// Directed bench for samm_feeder: M=2 hand-computed skew and M=8 stress cases.
module tb_samm_feeder;
  import samm_pkg::*;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  logic         in_dv2, mul_done2, in_rdy2, out_dv2;
  logic [31:0]  mat_a2, mat_b2, out_a2;
  logic         in_dv8, mul_done8, in_rdy8, out_dv8;
  logic [511:0] mat_a8, mat_b8, ea, eb;
  logic [127:0] out_a8;

  int checks = 0;
  int errors = 0;

  samm_feeder #(.N(8), .M(2)) u_dut2 (
    .Clk(Clk), .Rst(Rst), .In_Dv(in_dv2), .Mat_A(mat_a2), .Mat_B(mat_b2),
    .Mul_Done(mul_done2), .In_Rdy(in_rdy2), .Out_Dv(out_dv2), .Out_A(out_a2)
  );

  samm_feeder #(.N(8), .M(8)) u_dut8 (
    .Clk(Clk), .Rst(Rst), .In_Dv(in_dv8), .Mat_A(mat_a8), .Mat_B(mat_b8),
    .Mul_Done(mul_done8), .In_Rdy(in_rdy8), .Out_Dv(out_dv8), .Out_A(out_a8)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [511:0] fill(input logic [7:0] v);
    return {64{v}};
  endfunction

  function automatic logic [511:0] pat(input int base);
    logic [511:0] m;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        m[(r*8+c)*8 +: 8] = 8'(base + r*8 + c);
    return m;
  endfunction

  // Expected wavefront: hor j = A[j][t-j], ver j = B[t-j][j], else 0.
  function automatic logic [127:0] exp8(input logic [511:0] a, input logic [511:0] b, input int t);
    logic [127:0] res;
    int d;
    res = '0;
    for (int j = 0; j < 8; j++) begin
      d = t - j;
      if (d >= 0 && d <= 7) begin
        res[j*8 +: 8]      = elem(a, 32'(j), 32'(d));
        res[64 + j*8 +: 8] = elem(b, 32'(d), 32'(j));
      end
    end
    return res;
  endfunction

  logic [31:0] exp2a [3];
  logic [31:0] exp2b [3];

  initial begin
    exp2a = '{32'h0005_0001, 32'h0607_0302, 32'h0800_0400};
    exp2b = '{32'h000E_000A, 32'h0F10_0C0B, 32'h1100_0D00};
    Rst = 1'b1;
    in_dv2 = 1'b0; mul_done2 = 1'b0; mat_a2 = '0; mat_b2 = '0;
    in_dv8 = 1'b0; mul_done8 = 1'b0; mat_a8 = '0; mat_b8 = '0;
    tick; tick;
    Rst = 1'b0;
    check("rst_rdy2", in_rdy2, 1);
    check("rst_dv2", out_dv2, 0);
    check("rst_a2", out_a2, 0);
    check("rst_rdy8", in_rdy8, 1);
    check("rst_dv8", out_dv8, 0);
    check("rst_a8", out_a8, 0);

    // M=2 basic skew
    mat_a2 = 32'h0403_0201; mat_b2 = 32'h0807_0605; in_dv2 = 1'b1;
    tick;
    in_dv2 = 1'b0;
    check("m2_rdy_low", in_rdy2, 0);
    check("m2_dv_lat", out_dv2, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check($sformatf("m2_dv_t%0d", i), out_dv2, 1);
      check($sformatf("m2_a_t%0d", i), out_a2, exp2a[i]);
    end
    tick;
    check("m2_dv_end", out_dv2, 0);
    check("m2_a_end", out_a2, 0);
    check("m2_wait_rdy", in_rdy2, 0);
    tick; tick;
    check("m2_still_wait", in_rdy2, 0);

    // Mul_Done and In_Dv together in WAIT: return to IDLE only
    mat_a2 = 32'h0D0C_0B0A; mat_b2 = 32'h1110_0F0E;
    mul_done2 = 1'b1; in_dv2 = 1'b1;
    tick;
    mul_done2 = 1'b0;
    check("sim_rdy", in_rdy2, 1);
    check("sim_dv", out_dv2, 0);
    tick;
    in_dv2 = 1'b0;
    check("sim_cap", in_rdy2, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check($sformatf("sim_dv_t%0d", i), out_dv2, 1);
      check($sformatf("sim_a_t%0d", i), out_a2, exp2b[i]);
    end
    tick;
    check("sim_dv_end", out_dv2, 0);
    mul_done2 = 1'b1;
    tick;
    mul_done2 = 1'b0;
    check("sim_rdy_back", in_rdy2, 1);

    // M=8 signed extremes with back-pressure pulses
    ea = fill(8'h80); eb = fill(8'h7F);
    mat_a8 = ea; mat_b8 = eb; in_dv8 = 1'b1;
    tick;
    in_dv8 = 1'b0;
    for (int t = 0; t < 15; t++) begin
      if (t == 5) begin
        in_dv8 = 1'b1; mat_a8 = fill(8'h11); mat_b8 = fill(8'h22);
      end
      tick;
      in_dv8 = 1'b0;
      check($sformatf("ext_dv_t%0d", t), out_dv8, 1);
      check($sformatf("ext_a_t%0d", t), out_a8, exp8(ea, eb, t));
      if (t == 0) check("ext_hand_t0", out_a8, (128'h7F << 64) | 128'h80);
      if (t == 7) check("ext_hand_t7", out_a8, {{8{8'h7F}}, {8{8'h80}}});
      if (t == 14) check("ext_hand_t14", out_a8, (128'h7F << 120) | (128'h80 << 56));
    end
    tick;
    check("ext_dv_end", out_dv8, 0);
    check("ext_a_end", out_a8, 0);
    in_dv8 = 1'b1;
    tick;
    in_dv8 = 1'b0;
    check("bp_wait_rdy", in_rdy8, 0);
    check("bp_wait_dv", out_dv8, 0);
    mul_done8 = 1'b1;
    tick;
    mul_done8 = 1'b0;
    check("bp_rdy_back", in_rdy8, 1);
    tick;
    check("bp_no_reload", out_dv8, 0);

    // Reset at step 3
    ea = pat(1); eb = pat(8'h40);
    mat_a8 = ea; mat_b8 = eb; in_dv8 = 1'b1;
    tick;
    in_dv8 = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick;
      check($sformatf("pre_rst_a_t%0d", t), out_a8, exp8(ea, eb, t));
    end
    Rst = 1'b1;
    tick;
    Rst = 1'b0;
    check("mid_rst_dv", out_dv8, 0);
    check("mid_rst_a", out_a8, 0);
    check("mid_rst_rdy", in_rdy8, 1);

    // Fresh load after reset
    ea = pat(8'h81); eb = pat(8'h05);
    mat_a8 = ea; mat_b8 = eb; in_dv8 = 1'b1;
    tick;
    in_dv8 = 1'b0;
    for (int t = 0; t < 15; t++) begin
      tick;
      check($sformatf("fresh_dv_t%0d", t), out_dv8, 1);
      check($sformatf("fresh_a_t%0d", t), out_a8, exp8(ea, eb, t));
    end
    tick;
    check("fresh_dv_end", out_dv8, 0);
    mul_done8 = 1'b1;
    tick;
    mul_done8 = 1'b0;
    check("fresh_rdy_back", in_rdy8, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
